imply_drain: RTL and testbench

Read-side controller for the implication stack in the DPLL datapath. On `start` it pops the stack until it is empty and forwards each implied literal (variable, value) to the assignment/trail logic over a valid/ready handshake. On `flush` (conflict or backtrack) it discards the remaining entries without forwarding them. It sits between `imply_stack` (upstream, written by BCP) and the variable-state/trail update logic (downstream).

---
 rtl/sat_pkg.sv | 33 +++
 rtl/imply_stack.sv | 79 +++++++
 rtl/imply_drain.sv | 163 ++++++++++++++++
 tb/tb_imply_drain.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sat_pkg
// Description : Shared types for the DPLL datapath. It holds the literal
//               variable width, the packed literal record used by the
//               implication stack, and the state encoding of the
//               implication-stack drain controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sat_pkg;

    // Width of a literal's variable index.
    localparam int VAR_W = 9;

    // One implied literal as it is stored on the implication stack.
    typedef struct packed {
        logic [VAR_W-1:0] var_id;
        logic             val;
        logic             implied;
    } lit_t;

    // States of the drain controller.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_CAP   = 3'd2,
        ST_SEND  = 3'd3,
        ST_FLUSH = 3'd4,
        ST_FIN   = 3'd5
    } drain_state_e;

endpackage
`default_nettype wire

// File: rtl/imply_stack.sv
`default_nettype none
// ============================================================================
// Module      : imply_stack
// Description : LIFO of implied literals that BCP writes. A push or pop is
//               en=1 at a rising edge, with rw=1 for a push and rw=0 for a pop.
//               A popped entry is registered onto the *_out ports and stays
//               there until the next pop. A push when full and a pop when
//               empty are both ignored.
// Ports       : clock, reset (async, active-low)
//               en, rw                         access strobe / direction
//               variable_in, val_in, type_in   entry to push
//               variable_out, val_out, type_out last popped entry
//               empty, full                    occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module imply_stack
    import sat_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             rw,
    input  logic [VAR_W-1:0] variable_in,
    input  logic             val_in,
    input  logic             type_in,
    output logic [VAR_W-1:0] variable_out,
    output logic             val_out,
    output logic             type_out,
    output logic             empty,
    output logic             full
);

    localparam int c_addr_w = $clog2(DEPTH);
    // The pointer needs one more bit than the address so that it can hold
    // DEPTH itself.
    localparam int c_ptr_w  = c_addr_w + 1;

    lit_t                r_mem [DEPTH];
    lit_t                r_out;
    logic [c_ptr_w-1:0]  r_sp;
    logic                w_push;
    logic                w_pop;
    logic [c_addr_w-1:0] w_wr_addr;
    logic [c_addr_w-1:0] w_rd_addr;

    assign empty     = (r_sp == '0);
    assign full      = (r_sp == c_ptr_w'(DEPTH));
    assign w_push    = en && rw && !full;
    assign w_pop     = en && !rw && !empty;
    assign w_wr_addr = c_addr_w'(r_sp);
    assign w_rd_addr = c_addr_w'(r_sp - c_ptr_w'(1));

    // The storage array has no reset. The stack pointer alone says what is valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[w_wr_addr] <= {variable_in, val_in, type_in};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sp  <= '0;
            r_out <= '0;
        end else if (w_push) begin
            r_sp <= r_sp + c_ptr_w'(1);
        end else if (w_pop) begin
            r_sp  <= r_sp - c_ptr_w'(1);
            r_out <= r_mem[w_rd_addr];
        end
    end

    assign variable_out = r_out.var_id;
    assign val_out      = r_out.val;
    assign type_out     = r_out.implied;

endmodule
`default_nettype wire

// File: rtl/imply_drain.sv
`default_nettype none
// ============================================================================
// Module      : imply_drain
// Description : Read-side controller for the implication stack. On start it
//               pops the stack until the stack is empty. It forwards each
//               literal downstream over a valid/ready handshake. On flush it
//               pops the remaining entries and discards them.
// Ports       : clock, reset (async, active-low)
//               start, flush                   control requests
//               stk_empty, stk_type/val/var    stack status and entry
//               stk_en, stk_rw                 stack pop strobe (rw fixed 0)
//               asg_valid, asg_ready           downstream handshake
//               asg_var, asg_val, asg_implied  forwarded literal
//               busy, done, count              status
// Revision    : 1.0 - initial release
// ============================================================================
module imply_drain
    import sat_pkg::*;
#(
    parameter int VAR_W = sat_pkg::VAR_W,
    parameter int CNT_W = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic             stk_empty,
    input  logic             stk_type,
    input  logic             stk_val,
    input  logic [VAR_W-1:0] stk_var,
    output logic             stk_en,
    output logic             stk_rw,
    output logic             asg_valid,
    input  logic             asg_ready,
    output logic [VAR_W-1:0] asg_var,
    output logic             asg_val,
    output logic             asg_implied,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_count_max = '1;

    drain_state_e     r_state;
    drain_state_e     w_next_state;
    logic [VAR_W-1:0] r_asg_var;
    logic             r_asg_val;
    logic             r_asg_implied;
    logic [CNT_W-1:0] r_count;
    logic             w_capture;
    logic             w_count_clr;
    logic             w_count_inc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_count_clr  = 1'b0;
        w_count_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_count_clr = 1'b1;
                    if (stk_empty) begin
                        w_next_state = ST_FIN;
                    end else begin
                        w_next_state = ST_POP;
                    end
                end
            end
            ST_POP: begin
                // The pop this cycle still happens. Its entry is dropped
                // along with the rest if a flush comes in.
                if (flush) begin
                    w_next_state = ST_FLUSH;
                end else begin
                    w_next_state = ST_CAP;
                end
            end
            ST_CAP: begin
                if (flush) begin
                    w_next_state = ST_FLUSH;
                end else begin
                    w_capture    = 1'b1;
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                // When a handshake and a flush arrive together, the literal
                // is still delivered and counted.
                if (asg_ready) begin
                    w_count_inc = 1'b1;
                    if (flush) begin
                        w_next_state = ST_FLUSH;
                    end else if (stk_empty) begin
                        w_next_state = ST_FIN;
                    end else begin
                        w_next_state = ST_POP;
                    end
                end else if (flush) begin
                    w_next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (stk_empty) begin
                    w_next_state = ST_FIN;
                end
            end
            ST_FIN: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_asg_var     <= '0;
            r_asg_val     <= 1'b0;
            r_asg_implied <= 1'b0;
        end else if (w_capture) begin
            r_asg_var     <= stk_var;
            r_asg_val     <= stk_val;
            r_asg_implied <= stk_type;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_count_clr) begin
            r_count <= '0;
        end else if (w_count_inc && (r_count != c_count_max)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Every output is registered or decoded from the state register only.
    // In FLUSH the strobe is decoded from the state alone. On the last FLUSH
    // cycle it can therefore hit an empty stack, and the stack ignores that
    // access.
    assign stk_en      = (r_state == ST_POP) || (r_state == ST_FLUSH);
    assign stk_rw      = 1'b0;
    assign asg_valid   = (r_state == ST_SEND);
    assign asg_var     = r_asg_var;
    assign asg_val     = r_asg_val;
    assign asg_implied = r_asg_implied;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_FIN);
    assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_imply_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_imply_drain
// Description : Self-checking bench for imply_drain connected to imply_stack.
//               The reference model is a pair of queues that hold what was
//               pushed. The expected forwarded stream is that content read in
//               reverse, cut short at a flush.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imply_drain;
    import sat_pkg::*;

    localparam int CNT_W = 10;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             flush;
    logic             asg_ready;
    logic             tb_push;
    logic [VAR_W-1:0] tb_var;
    logic             tb_val;

    logic             stk_empty, stk_full, stk_type, stk_val;
    logic [VAR_W-1:0] stk_var;
    logic             stk_en, stk_rw;
    logic             asg_valid, asg_val, asg_implied, busy, done;
    logic [VAR_W-1:0] asg_var;
    logic [CNT_W-1:0] count;

    always #5 clock = ~clock;

    imply_drain #(.VAR_W(VAR_W), .CNT_W(CNT_W)) u_dut (
        .clock(clock), .reset(reset), .start(start), .flush(flush),
        .stk_empty(stk_empty), .stk_type(stk_type), .stk_val(stk_val),
        .stk_var(stk_var), .stk_en(stk_en), .stk_rw(stk_rw),
        .asg_valid(asg_valid), .asg_ready(asg_ready), .asg_var(asg_var),
        .asg_val(asg_val), .asg_implied(asg_implied), .busy(busy),
        .done(done), .count(count)
    );

    // The bench pushes only while the drain is idle, so the two strobes are
    // simply ORed onto the stack's access port.
    imply_stack #(.DEPTH(512)) u_stack (
        .clock(clock), .reset(reset),
        .en(stk_en | tb_push), .rw(stk_rw | tb_push),
        .variable_in(tb_var), .val_in(tb_val), .type_in(1'b1),
        .variable_out(stk_var), .val_out(stk_val), .type_out(stk_type),
        .empty(stk_empty), .full(stk_full)
    );

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: what is currently on the stack, oldest first.
    int mq_var[$];
    bit mq_val[$];

    // Observations from the last drain run.
    int got_var[$];
    bit got_val[$];
    int pops, done_cnt, first_en, first_valid, en_seen;
    int held12, stab_err, implied_bad, valid_after_flush;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_lit(input int v, input bit b);
        tb_push = 1'b1;
        tb_var  = v[VAR_W-1:0];
        tb_val  = b;
        @(posedge clock);
        #1;
        tb_push = 1'b0;
        mq_var.push_back(v);
        mq_val.push_back(b);
    endtask

    // The caller raises start at #1 after an edge. This task then steps one
    // cycle at a time. In each cycle it observes the outputs and then drives
    // ready/flush/start for that cycle.
    // ready_mode: 0 = always ready, 1 = stall 4 cycles on the 2nd entry, 2 = random.
    task automatic run_drain(input string tag, input int ready_mode, input int flush_hs,
                             input bit rand_start, input int budget, output int done_iter);
        int  iter;
        int  tail;
        int  stalls;
        bit  flush_seen;
        bit  prev_stall;
        int  prev_var;
        bit  prev_val;
        got_var.delete(); got_val.delete();
        pops = 0; done_cnt = 0; first_en = -1; first_valid = -1; en_seen = 0;
        held12 = 0; stab_err = 0; implied_bad = 0; valid_after_flush = 0;
        done_iter = -1; iter = 0; tail = 0; stalls = 0;
        flush_seen = 0; prev_stall = 0; prev_var = 0; prev_val = 0;
        while (iter < budget && tail < 3) begin
            @(posedge clock);
            #1;
            start = 1'b0;
            flush = 1'b0;
            iter++;
            if (stk_en) begin
                en_seen++;
                if (first_en < 0) first_en = iter;
            end
            if (stk_en && !stk_empty) pops++;
            if (asg_valid && first_valid < 0) first_valid = iter;
            if (asg_valid && !asg_implied) implied_bad++;
            if (flush_seen && asg_valid) valid_after_flush++;
            if (done) begin
                done_cnt++;
                if (done_iter < 0) done_iter = iter;
            end
            if (prev_stall && (!asg_valid || int'(asg_var) != prev_var || asg_val != prev_val))
                stab_err++;
            case (ready_mode)
                1: begin
                    if (asg_valid && got_var.size() == 1 && stalls < 4) begin
                        asg_ready = 1'b0;
                        stalls++;
                    end else begin
                        asg_ready = 1'b1;
                    end
                end
                2:       asg_ready = ($urandom_range(0, 3) != 0);
                default: asg_ready = 1'b1;
            endcase
            if (asg_valid && !asg_ready && asg_var == 12) held12++;
            prev_stall = asg_valid && !asg_ready;
            prev_var   = int'(asg_var);
            prev_val   = asg_val;
            if (asg_valid && asg_ready) begin
                got_var.push_back(int'(asg_var));
                got_val.push_back(asg_val);
                if (flush_hs == got_var.size()) begin
                    flush = 1'b1;
                    flush_seen = 1'b1;
                end
            end
            if (rand_start && busy && $urandom_range(0, 7) == 0) start = 1'b1;
            if (done_iter >= 0) tail++;
        end
        start = 1'b0;
        flush = 1'b0;
        check_eq({tag, "_done_seen"}, 32'(done_iter >= 0), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int di;
        int n;
        int ord_err;
        int lost_dup;
        bit seen [512];

        reset = 1'b0; start = 1'b0; flush = 1'b0; asg_ready = 1'b0;
        tb_push = 1'b0; tb_var = '0; tb_val = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_stk_en", stk_en, 0);
        check_eq("rst_stk_rw", stk_rw, 0);
        check_eq("rst_asg_valid", asg_valid, 0);
        check_eq("rst_asg_var", asg_var, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_count", count, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_eq("rel_busy", busy, 0);

        // Reset mid-SEND
        push_lit(7, 1);
        push_lit(9, 0);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int i = 0; i < 10 && !asg_valid; i++) begin
            @(posedge clock);
            #1;
        end
        check_eq("t1_in_send", asg_valid, 1);
        check_eq("t1_send_var", asg_var, 9);
        #2;
        reset = 1'b0;
        #1;
        check_eq("t1_rst_valid", asg_valid, 0);
        check_eq("t1_rst_var", asg_var, 0);
        check_eq("t1_rst_busy", busy, 0);
        check_eq("t1_rst_stk_en", stk_en, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_eq("t1_busy_after", busy, 0);
        mq_var.delete(); mq_val.delete();

        // Basic drain in LIFO order
        push_lit(5, 1); push_lit(12, 0); push_lit(300, 1);
        start = 1'b1;
        run_drain("t2", 0, 0, 1'b0, 200, di);
        n = mq_var.size();
        check_eq("t2_n_fwd", got_var.size(), n);
        for (int i = 0; i < n && i < got_var.size(); i++) begin
            check_eq($sformatf("t2_var%0d", i), got_var[i], mq_var[n-1-i]);
            check_eq($sformatf("t2_val%0d", i), got_val[i], mq_val[n-1-i]);
        end
        check_eq("t2_count", count, n);
        check_eq("t2_done_pulses", done_cnt, 1);
        check_eq("t2_empty", stk_empty, 1);
        check_eq("t2_first_en", first_en, 1);
        check_eq("t2_first_valid", first_valid, 3);
        check_eq("t2_pops", pops, n);
        check_eq("t2_implied", implied_bad, 0);
        mq_var.delete(); mq_val.delete();

        // Backpressure on the second entry
        push_lit(5, 1); push_lit(12, 0); push_lit(300, 1);
        start = 1'b1;
        run_drain("t3", 1, 0, 1'b0, 200, di);
        check_eq("t3_held12", held12, 4);
        check_eq("t3_stable", stab_err, 0);
        check_eq("t3_pops", pops, 3);
        check_eq("t3_count", count, 3);
        check_eq("t3_n_fwd", got_var.size(), 3);
        if (got_var.size() >= 2) check_eq("t3_var1", got_var[1], 12);
        mq_var.delete(); mq_val.delete();

        // Start on an empty stack
        start = 1'b1;
        run_drain("t4", 0, 0, 1'b0, 50, di);
        check_eq("t4_done_iter", di, 1);
        check_eq("t4_count", count, 0);
        check_eq("t4_en_seen", en_seen, 0);
        check_eq("t4_done_pulses", done_cnt, 1);

        // Flush together with the 2nd handshake
        for (int i = 0; i < 6; i++) push_lit(40 + 3 * i, $urandom_range(0, 1));
        start = 1'b1;
        run_drain("t5", 0, 2, 1'b0, 200, di);
        n = mq_var.size();
        check_eq("t5_count", count, 2);
        check_eq("t5_n_fwd", got_var.size(), 2);
        for (int i = 0; i < 2 && i < got_var.size(); i++)
            check_eq($sformatf("t5_var%0d", i), got_var[i], mq_var[n-1-i]);
        check_eq("t5_pops", pops, 6);
        check_eq("t5_valid_after_flush", valid_after_flush, 0);
        check_eq("t5_empty", stk_empty, 1);
        check_eq("t5_done_pulses", done_cnt, 1);
        mq_var.delete(); mq_val.delete();

        // Full stack, random ready, stray start pulses while busy
        for (int i = 0; i < 512; i++) push_lit(i, $urandom_range(0, 1));
        check_eq("t6_full", stk_full, 1);
        start = 1'b1;
        run_drain("t6", 2, 0, 1'b1, 20000, di);
        n = mq_var.size();
        check_eq("t6_count", count, 512);
        check_eq("t6_n_fwd", got_var.size(), n);
        ord_err = 0;
        lost_dup = 0;
        foreach (seen[i]) seen[i] = 1'b0;
        for (int i = 0; i < got_var.size(); i++) begin
            if (i >= n || got_var[i] != mq_var[n-1-i] || got_val[i] != mq_val[n-1-i]) ord_err++;
            if (got_var[i] >= 0 && got_var[i] < 512) begin
                if (seen[got_var[i]]) lost_dup++;
                seen[got_var[i]] = 1'b1;
            end
        end
        foreach (seen[i]) if (!seen[i]) lost_dup++;
        check_eq("t6_order_errors", ord_err, 0);
        check_eq("t6_lost_or_dup", lost_dup, 0);
        check_eq("t6_stable", stab_err, 0);
        check_eq("t6_empty", stk_empty, 1);
        check_eq("t6_done_pulses", done_cnt, 1);
        check_eq("t6_pops", pops, 512);
        mq_var.delete(); mq_val.delete();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
